// File: rtl/bsg_tun_dmx_credit_split_if.sv
// Tunnel demux bundle: upstream word handshake, per-channel
// delivery, credit returns and status. slave = demux, master = driver.
interface bsg_tun_dmx_credit_split_if #(
    parameter int width_p    = 64,
    parameter int num_chan_p = 3
);
    logic                  valid_i;
    logic [width_p-1:0]    data_i;
    logic                  yumi_o;
    logic [num_chan_p-1:0] v_o;
    logic [width_p-1:0]    data_o;
    logic [num_chan_p-1:0] credit_i;
    logic [7:0]            drop_cnt_o;
    logic                  err_o;

    modport slave (
        input  valid_i, data_i, credit_i,
        output yumi_o, v_o, data_o,
        output drop_cnt_o, err_o
    );

    modport master (
        output valid_i, data_i, credit_i,
        input  yumi_o, v_o, data_o,
        input  drop_cnt_o, err_o
    );
endinterface

// File: rtl/bsg_tun_dmx_credit_split.sv
// Credit-based tunnel demux: routes words by 2-bit top field to one of
// num_chan_p channels, drops illegal channels. Ports: clk_i, reset_n_i, tun.
module bsg_tun_dmx_credit_split #(
    parameter int width_p    = 64,
    parameter int num_chan_p = 3,
    parameter int credits_p  = 4
) (
    input  logic clk_i,
    input  logic reset_n_i,
    bsg_tun_dmx_credit_split_if.slave tun
);
    localparam logic [2:0] nchan_lp = 3'(num_chan_p);
    localparam logic [3:0] cred_lp  = 4'(credits_p);

    logic [1:0]            chan;
    logic                  legal;
    logic                  yumi;
    logic [3:0]            has_cred;
    logic [num_chan_p-1:0] send;
    logic [3:0]            cnt [num_chan_p];

    logic [num_chan_p-1:0] v_q;
    logic [width_p-1:0]    data_q;
    logic [7:0]            drop_q;
    logic                  err_q;

    assign chan  = tun.data_i[width_p-1 -: 2];
    assign legal = {1'b0, chan} < nchan_lp;

    // Padded to 4 so an illegal chan never indexes past the array.
    always_comb begin
        has_cred = '0;
        for (int c = 0; c < num_chan_p; c++)
            has_cred[c] = (cnt[c] != 4'd0);
    end

    assign yumi = reset_n_i & tun.valid_i
                & (~legal | has_cred[chan]);

    always_comb begin
        send = '0;
        for (int c = 0; c < num_chan_p; c++)
            send[c] = yumi & legal & (chan == 2'(c));
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_q    <= '0;
            data_q <= '0;
            drop_q <= '0;
            err_q  <= 1'b0;
            for (int c = 0; c < num_chan_p; c++)
                cnt[c] <= cred_lp;
        end else begin
            v_q <= send;
            if (yumi & legal)
                data_q <= tun.data_i;
            if (yumi & ~legal & (drop_q != 8'hff))
                drop_q <= drop_q + 8'd1;
            // Send and return in one cycle cancel out.
            for (int c = 0; c < num_chan_p; c++) begin
                unique case (1'b1)
                    send[c] & ~tun.credit_i[c]:
                        cnt[c] <= cnt[c] - 4'd1;
                    ~send[c] & tun.credit_i[c]: begin
                        if (cnt[c] == cred_lp)
                            err_q <= 1'b1;
                        else
                            cnt[c] <= cnt[c] + 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign tun.yumi_o     = yumi;
    assign tun.v_o        = v_q;
    assign tun.data_o     = data_q;
    assign tun.drop_cnt_o = drop_q;
    assign tun.err_o      = err_q;
endmodule
